pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the 5-stage core. It drives the per-stage stall vector consumed by the PC register and the if_id, id_ex, ex_mem and mem_wb pipeline registers. It sequences the one-cycle pipeline flush and PC redirect on exceptions, and passes taken-branch redirects from ID to the PC register. It also runs a stall watchdog and a stall-cycle performance counter.

Parameters:
ADDR_W, 32, instruction address width; matches the instruction address bus width.
STALL_W, 6, stall vector width. Bit0 PC, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved.
MAX_STALL, 255, consecutive PC-stall cycles before the watchdog fires; must be at least 2.
CNT_W, 32, width of the performance counter.

Ports:
clk  in  1  core clock; all state updates on the rising edge.
rst  in  1  reset; asynchronous, active-low.
stallreq_id  in  1  ID load-use hazard; hold ID and earlier stages.
stallreq_ex  in  1  EX multi-cycle operation busy; hold EX and earlier stages.
branch_req  in  1  ID resolved a taken branch or jump.
branch_pc  in  ADDR_W  branch target.
flush_req  in  1  MEM stage raised an exception or eret.
flush_pc  in  ADDR_W  exception or return target.
stall  out  STALL_W  per-stage hold vector.
flush  out  1  clears all pipeline registers to their reset contents.
pc_redirect  out  1  PC register loads new_pc this edge.
new_pc  out  ADDR_W  redirect target.
stall_timeout  out  1  sticky watchdog flag.
stall_cycles  out  CNT_W  count of cycles with stall[0]=1.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to RUN.
  - flush=0, pc_redirect=0, new_pc=0, stall=0, stall_timeout=0, stall_cycles=0, watchdog count=0.
  - While rst=0, every output is forced to these values regardless of inputs.
- FSM has two states, RUN and FLUSH.
- RUN:
  - stall is combinational, in the same cycle as the requests:
    - stallreq_ex=1 gives 6'b001111 (takes priority over stallreq_id).
    - Otherwise stallreq_id=1 gives 6'b000111.
    - Otherwise 6'b000000.
  - Branch: pc_redirect=1 and new_pc=branch_pc combinationally only when branch_req=1, stall[0]=0 and flush_req=0.
    - A branch held by a stall is re-presented by ID, so no latching is needed.
  - flush_req=1 at a rising edge: latch flush_pc into new_pc register and move to FLUSH.
  - flush_req beats a same-cycle branch_req, because the branch is younger and is suppressed.
- FLUSH (exactly one cycle):
  - flush=1, pc_redirect=1, new_pc=latched flush_pc, stall=6'b000000 regardless of requests.
  - Always returns to RUN on the next edge.
  - flush_req sampled in FLUSH is ignored: a flush is generated at most once per two cycles.
- Latency summary:
  - Stall and branch redirect take 0 cycles.
  - Exception flush takes 1 cycle.
- Watchdog:
  - Counts consecutive rising edges with stall[0]=1, saturating at MAX_STALL.
  - Clears on any edge with stall[0]=0 or in FLUSH.
  - When the count reaches MAX_STALL, stall_timeout sets and stays set until reset.
- stall_cycles:
  - Increments on each edge with stall[0]=1.
  - Wraps modulo 2^CNT_W with no saturation.
  - Not cleared by flush.
- stall[5] is always 0.

Decomposition:
- Shared defines header holds:
  - RstEnable (for rst, defined as 1'b0)
  - ZeroWord
  - InstAddrBus
  - Stall vector constants: STALL_NONE, STALL_ID, STALL_EX
  - FSM state encodings: RUN=1'b0, FLUSH=1'b1
- One natural sub-module: stall_watchdog, holding the saturating counter, sticky flag and perf counter.
- The FSM and stall mux stay in pipe_ctrl.

Test Plan:
1. Reset release with all requests 0 -> stall=0, flush=0, pc_redirect=0, new_pc=0, stall_timeout=0, stall_cycles=0. Assert rst=0 mid-FLUSH -> all outputs 0 immediately, without waiting for a clock.
2. stallreq_id=1 for 3 cycles, then stallreq_ex=1 together with stallreq_id=1 for 2 cycles -> stall=000111 for 3 cycles then 001111 for 2 cycles; stall_cycles=5.
3. branch_req=1, branch_pc=0x00000040 with no stall -> pc_redirect=1, new_pc=0x40 in the same cycle. Repeat with stallreq_ex=1 -> pc_redirect=0.
4. flush_req=1, flush_pc=0x00000120 together with branch_req=1 and stallreq_id=1 for one cycle -> that cycle pc_redirect=0 and stall=000111. Next cycle flush=1, pc_redirect=1, new_pc=0x120, stall=0. Cycle after that flush=0.
5. flush_req held high for 4 cycles -> flush pulses on cycles 2 and 4 only.
6. MAX_STALL=4 with stallreq_ex held for 6 cycles -> stall_timeout rises after the 4th stalled edge. It stays 1 after the stall ends, until the next reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, stall vector encodings and FSM states for the pipeline controller.
// No logic; no latency or backpressure of its own.
package pipe_ctrl_pkg;

  localparam logic RstEnable = 1'b0;

  localparam int INST_ADDR_W = 32;
  typedef logic [INST_ADDR_W-1:0] InstAddrBus;
  localparam InstAddrBus ZeroWord = '0;

  // Bit0 PC, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 reserved
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the sequencing controller.
// Stall/branch paths are combinational; flush is registered one cycle after its request.
interface pipe_ctrl_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 32
);

  logic               stallreq_id;
  logic               stallreq_ex;
  logic               branch_req;
  logic [ADDR_W-1:0]  branch_pc;
  logic               flush_req;
  logic [ADDR_W-1:0]  flush_pc;

  logic [STALL_W-1:0] stall;
  logic               flush;
  logic               pc_redirect;
  logic [ADDR_W-1:0]  new_pc;
  logic               stall_timeout;
  logic [CNT_W-1:0]   stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, branch_req, branch_pc, flush_req, flush_pc,
    input  stall, flush, pc_redirect, new_pc, stall_timeout, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, branch_req, branch_pc, flush_req, flush_pc,
    output stall, flush, pc_redirect, new_pc, stall_timeout, stall_cycles
  );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Saturating consecutive-stall watchdog with sticky timeout, plus a wrapping stall-cycle counter.
// Updates on each edge; no backpressure.
module pipe_ctrl_stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_STALL = 255,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall_pc,
  input  logic             i_flush,
  output logic             o_stall_timeout,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int WD_W = $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

  logic [WD_W-1:0]  r_wd_cnt;
  logic [WD_W-1:0]  w_wd_nxt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cycles;
  logic             w_count;

  assign w_count = i_stall_pc & ~i_flush;

  always_comb begin
    w_wd_nxt = r_wd_cnt;
    if (!w_count) begin
      w_wd_nxt = '0;
    end else if (r_wd_cnt != WD_MAX) begin
      w_wd_nxt = r_wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
      r_cycles  <= '0;
    end else begin
      r_wd_cnt <= w_wd_nxt;
      // Flag rises on the same edge the count reaches the limit
      if (w_wd_nxt == WD_MAX) begin
        r_timeout <= 1'b1;
      end
      if (i_stall_pc) begin
        r_cycles <= r_cycles + 1'b1;
      end
    end
  end

  assign o_stall_timeout = r_timeout;
  assign o_stall_cycles  = r_cycles;

endmodule

// File: rtl/pipe_ctrl.sv
// 5-stage pipeline sequencer: stall vector, branch redirect, one-cycle exception flush.
// Stall/branch 0 cycles, flush 1 cycle after request; flush requests during FLUSH are dropped.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int STALL_W   = 6,
  parameter int MAX_STALL = 255,
  parameter int CNT_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  state_e             r_state;
  logic [ADDR_W-1:0]  r_new_pc;
  logic [STALL_W-1:0] w_stall_run;
  logic [STALL_W-1:0] w_stall;
  logic               w_in_flush;
  logic               w_branch;

  assign w_in_flush = (r_state == FLUSH);

  always_comb begin
    w_stall_run = STALL_W'(STALL_NONE);
    if (bus.stallreq_ex) begin
      w_stall_run = STALL_W'(STALL_EX);
    end else if (bus.stallreq_id) begin
      w_stall_run = STALL_W'(STALL_ID);
    end
  end

  // Reset gating keeps the combinational outputs quiet while rst is held
  assign w_stall = (rst == RstEnable || w_in_flush) ? STALL_W'(STALL_NONE) : w_stall_run;

  // A branch held by a stall is re-presented by ID, and a same-cycle flush kills it
  assign w_branch = (rst != RstEnable) && !w_in_flush && bus.branch_req
                    && !w_stall[0] && !bus.flush_req;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state  <= RUN;
      r_new_pc <= ADDR_W'(ZeroWord);
    end else begin
      case (r_state)
        RUN: begin
          if (bus.flush_req) begin
            r_new_pc <= bus.flush_pc;
            r_state  <= FLUSH;
          end
        end
        FLUSH: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  pipe_ctrl_stall_watchdog #(
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) u_watchdog (
    .clk             (clk),
    .rst             (rst),
    .i_stall_pc      (w_stall[0]),
    .i_flush         (w_in_flush),
    .o_stall_timeout (bus.stall_timeout),
    .o_stall_cycles  (bus.stall_cycles)
  );

  assign bus.stall       = w_stall;
  assign bus.flush       = w_in_flush;
  assign bus.pc_redirect = w_branch | w_in_flush;
  assign bus.new_pc      = w_branch ? bus.branch_pc : r_new_pc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plan scenarios plus randomized traffic against a behavioural model of the controller.
module tb_pipe_ctrl;

  localparam int ADDR_W    = 32;
  localparam int STALL_W   = 6;
  localparam int CNT_W     = 32;
  localparam int MAX_STALL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.ADDR_W(ADDR_W), .STALL_W(STALL_W), .CNT_W(CNT_W)) bus ();

  pipe_ctrl #(
    .ADDR_W    (ADDR_W),
    .STALL_W   (STALL_W),
    .MAX_STALL (MAX_STALL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  bit          m_in_flush;
  logic [31:0] m_target;
  int          m_wd;
  bit          m_timeout;
  logic [31:0] m_cycles;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_flush = 0;
    m_target   = '0;
    m_wd       = 0;
    m_timeout  = 0;
    m_cycles   = '0;
  endtask

  task automatic drive(input bit ex, input bit id, input bit br, input logic [31:0] bpc,
                       input bit fr, input logic [31:0] fpc);
    bus.stallreq_ex = ex;
    bus.stallreq_id = id;
    bus.branch_req  = br;
    bus.branch_pc   = bpc;
    bus.flush_req   = fr;
    bus.flush_pc    = fpc;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, 64'(bus.stall), 64'd0);
    chk({tag, "_flush"}, 64'(bus.flush), 64'd0);
    chk({tag, "_redir"}, 64'(bus.pc_redirect), 64'd0);
    chk({tag, "_newpc"}, 64'(bus.new_pc), 64'd0);
    chk({tag, "_tmo"}, 64'(bus.stall_timeout), 64'd0);
    chk({tag, "_cyc"}, 64'(bus.stall_cycles), 64'd0);
  endtask

  task automatic check_outputs(input string tag);
    bit          pc_held;
    bit          redir;
    logic [5:0]  e_stall;
    logic [31:0] e_pc;
    pc_held = !m_in_flush && (bus.stallreq_ex || bus.stallreq_id);
    if (m_in_flush)           e_stall = 6'd0;
    else if (bus.stallreq_ex) e_stall = 6'd15;
    else if (bus.stallreq_id) e_stall = 6'd7;
    else                      e_stall = 6'd0;
    redir = m_in_flush || (bus.branch_req && !pc_held && !bus.flush_req);
    e_pc  = m_in_flush ? m_target : bus.branch_pc;
    chk({tag, "_stall"}, 64'(bus.stall), 64'(e_stall));
    chk({tag, "_flush"}, 64'(bus.flush), 64'(m_in_flush));
    chk({tag, "_redir"}, 64'(bus.pc_redirect), 64'(redir));
    if (redir) chk({tag, "_newpc"}, 64'(bus.new_pc), 64'(e_pc));
    chk({tag, "_tmo"}, 64'(bus.stall_timeout), 64'(m_timeout));
    chk({tag, "_cyc"}, 64'(bus.stall_cycles), 64'(m_cycles));
  endtask

  task automatic model_edge();
    bit pc_held;
    pc_held = !m_in_flush && (bus.stallreq_ex || bus.stallreq_id);
    if (pc_held) begin
      m_cycles = m_cycles + 1;
      m_wd = (m_wd + 1 > MAX_STALL) ? MAX_STALL : m_wd + 1;
    end else begin
      m_wd = 0;
    end
    if (m_wd == MAX_STALL) m_timeout = 1;
    if (m_in_flush) begin
      m_in_flush = 0;
    end else if (bus.flush_req) begin
      m_in_flush = 1;
      m_target   = bus.flush_pc;
    end
  endtask

  // One clock: inputs applied after the edge, outputs checked at negedge, model advanced at posedge
  task automatic cyc(input string tag, input bit ex, input bit id, input bit br,
                     input logic [31:0] bpc, input bit fr, input logic [31:0] fpc);
    drive(ex, id, br, bpc, fr, fpc);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(1, 1, 1, 32'hDEAD_BEE0, 1, 32'h0000_0BAD);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    drive(0, 0, 0, '0, 0, '0);
    rst = 1'b1;
    model_reset();
    check_zero("rst_rel");
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    drive(0, 0, 0, '0, 0, '0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: reset state, then async reset in the middle of FLUSH
    do_reset();
    cyc("t1_idle", 0, 0, 0, '0, 0, '0);
    cyc("t1_req", 0, 0, 0, '0, 1, 32'h0000_0200);
    #2;
    chk("t1_in_flush", 64'(bus.flush), 64'd1);
    rst = 1'b0;
    bus.stallreq_ex = 1'b1;
    bus.branch_req  = 1'b1;
    #1;
    check_zero("t1_midflush");
    do_reset();

    // 2: ID stall then EX+ID stall
    for (int i = 0; i < 3; i++) cyc("t2_id", 0, 1, 0, '0, 0, '0);
    for (int i = 0; i < 2; i++) cyc("t2_ex", 1, 1, 0, '0, 0, '0);
    cyc("t2_after", 0, 0, 0, '0, 0, '0);
    chk("t2_cycles5", 64'(bus.stall_cycles), 64'd5);

    // 3: branch redirect, then suppressed by EX stall
    do_reset();
    cyc("t3_br", 0, 0, 1, 32'h0000_0040, 0, '0);
    cyc("t3_br_stall", 1, 0, 1, 32'h0000_0040, 0, '0);

    // 4: flush beats branch and ID stall
    cyc("t4_req", 0, 1, 1, 32'h0000_0080, 1, 32'h0000_0120);
    drive(0, 0, 0, '0, 0, '0);
    @(negedge clk);
    chk("t4_flush_pc", 64'(bus.new_pc), 64'h120);
    check_outputs("t4_flush");
    @(posedge clk);
    model_edge();
    #1;
    cyc("t4_done", 0, 0, 0, '0, 0, '0);

    // 5: flush_req held four cycles
    do_reset();
    for (int i = 0; i < 4; i++) cyc("t5_hold", 0, 0, 0, '0, 1, 32'h0000_1000 + 32'(i * 4));
    cyc("t5_end", 0, 0, 0, '0, 0, '0);

    // 6: watchdog with MAX_STALL=4
    do_reset();
    for (int i = 0; i < 6; i++) cyc("t6_ex", 1, 0, 0, '0, 0, '0);
    for (int i = 0; i < 3; i++) cyc("t6_idle", 0, 0, 0, '0, 0, '0);
    chk("t6_sticky", 64'(bus.stall_timeout), 64'd1);
    do_reset();
    chk("t6_cleared", 64'(bus.stall_timeout), 64'd0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      if (n % 300 == 299) do_reset();
      cyc("rnd",
          $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 4,
          $urandom_range(0, 9) < 4,
          $urandom,
          $urandom_range(0, 9) < 1,
          $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
